// File: rtl/pipe_writeback_elastic_vp.sv
// Elastic M->W pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, global hold, and x0 scalar-write suppression at capture.
module pipe_writeback_elastic_vp #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 6,
    localparam int unsigned DW        = LANES * LANE_WIDTH
) (
    input  logic                clock,
    input  logic                async_reset,
    input  logic                enabler,
    input  logic                flush,
    input  logic                valid_M,
    output logic                ready_M,
    input  logic [XLEN-1:0]     instruction_M,
    input  logic                write_scalar_reg_M,
    input  logic [1:0]          result_source_M,
    input  logic                write_vector_reg_M,
    input  logic [RD_WIDTH-1:0] rd_M,
    input  logic [DW-1:0]       ALU_result_bus_M,
    input  logic [DW-1:0]       read_data_bus_M,
    input  logic [XLEN-1:0]     PC_plus_4_M,
    output logic                valid_W,
    input  logic                ready_W,
    output logic [XLEN-1:0]     instruction_W,
    output logic                write_scalar_reg_W,
    output logic [1:0]          result_source_W,
    output logic                write_vector_reg_W,
    output logic [RD_WIDTH-1:0] rd_W,
    output logic [DW-1:0]       ALU_result_bus_W,
    output logic [DW-1:0]       read_data_bus_W,
    output logic [XLEN-1:0]     PC_plus_4_W
);

    localparam int unsigned RW = 2 * XLEN + 2 + RD_WIDTH + 2 * DW;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          accept;
    logic          emit;
    logic          ld_main_m;
    logic          ld_main_skid;
    logic          ld_skid;

    logic [RW-1:0] in_rest;
    logic          in_ws;
    logic [RW-1:0] main_rest;
    logic          main_ws;
    logic          main_wv;
    logic [RW-1:0] skid_rest;
    logic          skid_ws;
    logic          skid_wv;

    assign ready_M = enabler & (state != FULL);
    assign valid_W = (state != EMPTY);
    assign accept  = valid_M & ready_M;
    assign emit    = valid_W & ready_W & enabler;

    assign in_rest = {instruction_M, result_source_M, rd_M,
                      ALU_result_bus_M, read_data_bus_M, PC_plus_4_M};
    // Scalar writes to x0 are dropped when the entry is stored.
    assign in_ws   = write_scalar_reg_M & (rd_M[RD_WIDTH-2:0] != '0);

    // State register
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and storage-load decode
    always_comb begin
        state_nxt    = state;
        ld_main_m    = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (enabler) begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        ld_main_m = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        ld_main_m = 1'b1;
                    end else if (accept) begin
                        ld_skid   = 1'b1;
                        state_nxt = FULL;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        ld_main_skid = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Main and skid payload storage; flush clears only the write enables
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            main_rest <= '0;
            main_ws   <= 1'b0;
            main_wv   <= 1'b0;
            skid_rest <= '0;
            skid_ws   <= 1'b0;
            skid_wv   <= 1'b0;
        end else if (flush) begin
            main_ws   <= 1'b0;
            main_wv   <= 1'b0;
            skid_ws   <= 1'b0;
            skid_wv   <= 1'b0;
        end else begin
            if (ld_main_m) begin
                main_rest <= in_rest;
                main_ws   <= in_ws;
                main_wv   <= write_vector_reg_M;
            end else if (ld_main_skid) begin
                main_rest <= skid_rest;
                main_ws   <= skid_ws;
                main_wv   <= skid_wv;
            end
            if (ld_skid) begin
                skid_rest <= in_rest;
                skid_ws   <= in_ws;
                skid_wv   <= write_vector_reg_M;
            end
        end
    end

    assign {instruction_W, result_source_W, rd_W,
            ALU_result_bus_W, read_data_bus_W, PC_plus_4_W} = main_rest;
    assign write_scalar_reg_W = main_ws & valid_W;
    assign write_vector_reg_W = main_wv & valid_W;

endmodule

// File: tb/tb_pipe_writeback_elastic_vp.sv
// Directed bench for pipe_writeback_elastic_vp: pass-through, skid backpressure,
// flush, x0 suppression, hold and mid-cycle reset.
module tb_pipe_writeback_elastic_vp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DW   = 128;
    localparam int unsigned RDW  = 6;

    logic            clock;
    logic            async_reset;
    logic            enabler;
    logic            flush;
    logic            valid_M;
    logic            ready_M;
    logic [XLEN-1:0] instruction_M;
    logic            write_scalar_reg_M;
    logic [1:0]      result_source_M;
    logic            write_vector_reg_M;
    logic [RDW-1:0]  rd_M;
    logic [DW-1:0]   ALU_result_bus_M;
    logic [DW-1:0]   read_data_bus_M;
    logic [XLEN-1:0] PC_plus_4_M;
    logic            valid_W;
    logic            ready_W;
    logic [XLEN-1:0] instruction_W;
    logic            write_scalar_reg_W;
    logic [1:0]      result_source_W;
    logic            write_vector_reg_W;
    logic [RDW-1:0]  rd_W;
    logic [DW-1:0]   ALU_result_bus_W;
    logic [DW-1:0]   read_data_bus_W;
    logic [XLEN-1:0] PC_plus_4_W;

    int checks = 0;
    int errors = 0;

    pipe_writeback_elastic_vp dut (
        .clock              (clock),
        .async_reset        (async_reset),
        .enabler            (enabler),
        .flush              (flush),
        .valid_M            (valid_M),
        .ready_M            (ready_M),
        .instruction_M      (instruction_M),
        .write_scalar_reg_M (write_scalar_reg_M),
        .result_source_M    (result_source_M),
        .write_vector_reg_M (write_vector_reg_M),
        .rd_M               (rd_M),
        .ALU_result_bus_M   (ALU_result_bus_M),
        .read_data_bus_M    (read_data_bus_M),
        .PC_plus_4_M        (PC_plus_4_M),
        .valid_W            (valid_W),
        .ready_W            (ready_W),
        .instruction_W      (instruction_W),
        .write_scalar_reg_W (write_scalar_reg_W),
        .result_source_W    (result_source_W),
        .write_vector_reg_W (write_vector_reg_W),
        .rd_W               (rd_W),
        .ALU_result_bus_W   (ALU_result_bus_W),
        .read_data_bus_W    (read_data_bus_W),
        .PC_plus_4_W        (PC_plus_4_W)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        async_reset        = 1'b0;
        enabler            = 1'b0;
        flush              = 1'b0;
        valid_M            = 1'b0;
        ready_W            = 1'b0;
        instruction_M      = '0;
        write_scalar_reg_M = 1'b0;
        result_source_M    = 2'b00;
        write_vector_reg_M = 1'b0;
        rd_M               = '0;
        ALU_result_bus_M   = '0;
        read_data_bus_M    = '0;
        PC_plus_4_M        = '0;

        #2;
        chk("rst_valid_W", 128'(valid_W), 128'd0);
        chk("rst_ready_M", 128'(ready_M), 128'd0);
        chk("rst_instr_W", 128'(instruction_W), 128'd0);
        chk("rst_alu_W", ALU_result_bus_W, 128'd0);
        chk("rst_ws_W", 128'(write_scalar_reg_W), 128'd0);
        chk("rst_pc_W", 128'(PC_plus_4_W), 128'd0);

        #11;
        async_reset        = 1'b1;
        enabler            = 1'b1;
        ready_W            = 1'b1;
        valid_M            = 1'b1;
        instruction_M      = 32'hABCDEF01;
        rd_M               = 6'b011010;
        ALU_result_bus_M   = 128'h0123456789ABCDEF0123456789ABCDEF;
        read_data_bus_M    = 128'hFEDCBA9876543210FEDCBA9876543210;
        PC_plus_4_M        = 32'h80000004;
        write_scalar_reg_M = 1'b1;
        write_vector_reg_M = 1'b1;
        result_source_M    = 2'b10;
        #1;
        chk("post_rst_ready_M", 128'(ready_M), 128'd1);

        // Pass-through, 1-cycle latency
        step();
        chk("pt_valid_W", 128'(valid_W), 128'd1);
        chk("pt_instr_W", 128'(instruction_W), 128'hABCDEF01);
        chk("pt_rd_W", 128'(rd_W), 128'h1A);
        chk("pt_alu_W", ALU_result_bus_W, 128'h0123456789ABCDEF0123456789ABCDEF);
        chk("pt_rdata_W", read_data_bus_W, 128'hFEDCBA9876543210FEDCBA9876543210);
        chk("pt_pc_W", 128'(PC_plus_4_W), 128'h80000004);
        chk("pt_ws_W", 128'(write_scalar_reg_W), 128'd1);
        chk("pt_wv_W", 128'(write_vector_reg_W), 128'd1);
        chk("pt_rs_W", 128'(result_source_W), 128'd2);

        valid_M = 1'b0;
        step();
        chk("drain_valid_W", 128'(valid_W), 128'd0);
        chk("drain_ws_gated", 128'(write_scalar_reg_W), 128'd0);

        // Backpressure into the skid buffer
        ready_W = 1'b0;
        valid_M = 1'b1;
        instruction_M = 32'd1;
        step();
        chk("bp1_instr_W", 128'(instruction_W), 128'd1);
        chk("bp1_ready_M", 128'(ready_M), 128'd1);
        instruction_M = 32'd2;
        step();
        chk("bp2_instr_W", 128'(instruction_W), 128'd1);
        chk("bp2_ready_M_full", 128'(ready_M), 128'd0);
        instruction_M = 32'd3;
        step();
        chk("bp3_instr_W", 128'(instruction_W), 128'd1);
        chk("bp3_ready_M_full", 128'(ready_M), 128'd0);
        ready_W = 1'b1;
        step();
        chk("bp_drain2", 128'(instruction_W), 128'd2);
        chk("bp_drain2_ready_M", 128'(ready_M), 128'd1);
        step();
        chk("bp_drain3", 128'(instruction_W), 128'd3);
        chk("bp_drain3_valid", 128'(valid_W), 128'd1);
        valid_M = 1'b0;
        step();
        chk("bp_empty", 128'(valid_W), 128'd0);

        // Flush while FULL
        ready_W = 1'b0;
        valid_M = 1'b1;
        instruction_M = 32'd10;
        step();
        instruction_M = 32'd11;
        step();
        chk("fl_full_ready_M", 128'(ready_M), 128'd0);
        chk("fl_full_instr_W", 128'(instruction_W), 128'd10);
        flush = 1'b1;
        instruction_M = 32'hDEAD0000;
        step();
        chk("fl_valid_W", 128'(valid_W), 128'd0);
        chk("fl_ws_W", 128'(write_scalar_reg_W), 128'd0);
        chk("fl_wv_W", 128'(write_vector_reg_W), 128'd0);
        chk("fl_ready_M", 128'(ready_M), 128'd1);
        flush = 1'b0;
        valid_M = 1'b0;
        ready_W = 1'b1;
        step();
        chk("fl_stay_empty", 128'(valid_W), 128'd0);

        // x0 suppression
        valid_M = 1'b1;
        rd_M = 6'b000000;
        write_scalar_reg_M = 1'b1;
        write_vector_reg_M = 1'b1;
        instruction_M = 32'd20;
        step();
        chk("x0a_instr_W", 128'(instruction_W), 128'd20);
        chk("x0a_ws_W", 128'(write_scalar_reg_W), 128'd0);
        chk("x0a_wv_W", 128'(write_vector_reg_W), 128'd1);
        rd_M = 6'b100000;
        write_vector_reg_M = 1'b0;
        instruction_M = 32'd21;
        step();
        chk("x0b_instr_W", 128'(instruction_W), 128'd21);
        chk("x0b_ws_W", 128'(write_scalar_reg_W), 128'd0);
        chk("x0b_wv_W", 128'(write_vector_reg_W), 128'd0);
        rd_M = 6'b011010;
        instruction_M = 32'd22;
        step();
        chk("x0c_ws_W", 128'(write_scalar_reg_W), 128'd1);
        chk("x0c_rd_W", 128'(rd_W), 128'h1A);

        // Global hold in ONE
        enabler = 1'b0;
        instruction_M = 32'd30;
        #1;
        chk("hold_ready_M", 128'(ready_M), 128'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_instr_W", 128'(instruction_W), 128'd22);
            chk("hold_valid_W", 128'(valid_W), 128'd1);
        end
        enabler = 1'b1;
        step();
        chk("resume_instr_W", 128'(instruction_W), 128'd30);
        chk("resume_valid_W", 128'(valid_W), 128'd1);

        // Reset mid-cycle while FULL
        ready_W = 1'b0;
        instruction_M = 32'd40;
        step();
        chk("mr_full_ready_M", 128'(ready_M), 128'd0);
        #3;
        async_reset = 1'b0;
        #1;
        chk("mr_valid_W", 128'(valid_W), 128'd0);
        chk("mr_instr_W", 128'(instruction_W), 128'd0);
        #2;
        async_reset = 1'b1;
        ready_W = 1'b1;
        instruction_M = 32'd50;
        step();
        chk("mr_fresh_instr_W", 128'(instruction_W), 128'd50);
        chk("mr_fresh_valid_W", 128'(valid_W), 128'd1);
        valid_M = 1'b0;
        step();
        chk("mr_final_empty", 128'(valid_W), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_writeback_elastic_vp.md
Name: pipe_writeback_elastic_vp

Overview:
- Parametrised, elastic memory-to-writeback (M→W) pipeline stage for the scalar/vector core.
- Carries the instruction, control and lane-wide data buses from M to W with a valid/ready handshake and a 2-entry skid buffer, so a busy register-file write port (ready_W low) stalls M without dropping data.
- Supports synchronous flush (bubble injection) and a global hold (enabler).
- Suppresses scalar writes to x0 at capture.

Parameters:
- XLEN, 32, width of instruction and PC_plus_4 buses.
- LANES, 4, number of vector lanes.
- LANE_WIDTH, 32, bits per lane; data bus width DW = LANES*LANE_WIDTH.
- RD_WIDTH, 6, destination register address width; rd[RD_WIDTH-2:0]==0 denotes x0.

Ports:
- clock  in  1  single clock, rising edge.
- async_reset  in  1  asynchronous, active-low reset.
- enabler  in  1  global hold; 0 freezes all state.
- flush  in  1  synchronous kill of all held entries.
- valid_M  in  1  M-side entry valid.
- ready_M  out  1  stage can accept an entry.
- instruction_M  in  XLEN  instruction.
- write_scalar_reg_M  in  1  scalar RF write request.
- result_source_M  in  2  writeback mux select.
- write_vector_reg_M  in  1  vector RF write request.
- rd_M  in  RD_WIDTH  destination register.
- ALU_result_bus_M  in  DW  ALU result lanes.
- read_data_bus_M  in  DW  memory read lanes.
- PC_plus_4_M  in  XLEN  link value.
- valid_W  out  1  W-side entry valid.
- ready_W  in  1  writeback consumes entry this cycle.
- instruction_W, write_scalar_reg_W, result_source_W, write_vector_reg_W, rd_W, ALU_result_bus_W, read_data_bus_W, PC_plus_4_W  out  same widths as the M inputs  registered payload.

Behaviour:
- Reset (async_reset=0, immediate, independent of clock): state=EMPTY; valid_W=0; all payload outputs and skid contents=0. ready_M follows its formula, so it reads 1 when enabler=1.
- Accept = valid_M & ready_M. Emit = valid_W & ready_W.
- ready_M = enabler & (state != FULL). Combinational from registered state and enabler only; no path from valid_M or ready_W.
- Storage:
  - main register drives the *_W outputs directly.
  - skid register is hidden; it is used only in FULL.
- States: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid). valid_W = (state != EMPTY).
- Transitions, when enabler=1 and flush=0:
  - EMPTY: Accept → main<=M, ONE. Otherwise stay.
  - ONE: Accept&Emit → main<=M, ONE. Accept&!Emit → skid<=M, FULL. !Accept&Emit → EMPTY. Otherwise hold.
  - FULL: Emit → main<=skid, ONE (no Accept possible). Otherwise hold.
- Latency: an entry accepted on edge N appears on *_W after edge N (1 cycle) when the stage was EMPTY, or when it was ONE with Emit.
- Ordering is strictly FIFO; no entry is duplicated or lost.
- enabler=0: no state or payload change, ready_M=0. valid_W and payload remain visible, but Emit is not taken; ready_W is ignored.
- flush=1 at an edge: state<=EMPTY (valid_W=0), regardless of enabler, valid_M or ready_W. A same-cycle M entry is dropped, and ready_M's value that cycle is irrelevant.
  - Stored write_scalar_reg/write_vector_reg bits are cleared.
  - Other payload is don't-care but must not change when no capture occurs.
- x0 suppression: on capture into main or skid, the stored write_scalar_reg = write_scalar_reg_M & (rd_M[RD_WIDTH-2:0] != 0). write_vector_reg is unaffected.
- Output gating: write_scalar_reg_W and write_vector_reg_W read 0 whenever valid_W=0.
- Payload is captured only on Accept or skid→main move; otherwise it holds.
- All widths are straight copies. No arithmetic on the data path.

Test Plan:
- Reset then pass-through:
  - Stimulus: async_reset low at t=0, released at 13 ns. Then enabler=1, ready_W=1, valid_M=1, instruction_M=32'hABCDEF01, rd_M=6'b011010, ALU_result_bus_M=128'h0123456789ABCDEF0123456789ABCDEF, read_data_bus_M=128'hFEDCBA9876543210FEDCBA9876543210, PC_plus_4_M=32'h80000004, write_scalar_reg_M=1, write_vector_reg_M=1, result_source_M=2'b10.
  - Required: before release all outputs are 0. One edge after Accept, every *_W field equals its M input and valid_W=1.
- Backpressure/skid:
  - Stimulus: ready_W=0, then 3 consecutive entries with instruction_M = 1, 2, 3.
  - Required: entries 1 and 2 are accepted; ready_M=0 in FULL, so entry 3 is not accepted.
  - Stimulus: raise ready_W.
  - Required: W shows 1, then 2, then 3 in order, with no gaps once ready_M reasserts.
- Flush in FULL:
  - Stimulus: fill with 2 entries, then pulse flush with valid_M=1 and instruction_M=32'hDEAD0000.
  - Required: next cycle valid_W=0, both write enables 0, ready_M=1, and 32'hDEAD0000 never appears.
- x0 suppression:
  - Stimulus: rd_M=6'b000000 with write_scalar_reg_M=1 and write_vector_reg_M=1; then rd_M=6'b100000 with write_scalar_reg_M=1.
  - Required: both captures have write_scalar_reg_W=0; the first has write_vector_reg_W=1.
- Hold:
  - Stimulus: enabler=0 for 5 cycles while in ONE, with valid_M=1 and ready_W=1.
  - Required: ready_M=0, W payload and state unchanged.
  - Stimulus: enabler=1.
  - Required: normal Accept/Emit resumes.
- Reset mid-operation:
  - Stimulus: assert async_reset mid-cycle while in FULL.
  - Required: valid_W drops immediately (before the next edge); after release, the first Accept yields fresh data with 1-cycle latency.
